// File: rtl/burst_countdown_if.sv
// rtl/burst_countdown_if.sv - start/len handshake and step/index/count bus for burst_countdown
interface burst_countdown_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] len;
    logic             hold;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             step;
    logic [WIDTH-1:0] index;
    logic [WIDTH-1:0] count;
    logic             done;

    modport master (
        output start, len, hold, abort,
        input  ready, busy, step, index, count, done
    );

    modport slave (
        input  start, len, hold, abort,
        output ready, busy, step, index, count, done
    );
endinterface

// File: rtl/burst_countdown.sv
// rtl/burst_countdown.sv - burst length sequencer issuing one step per un-held cycle
// Optional macro AUTO_RELOAD_EN: DONE reloads the saved length and re-enters RUN.
module burst_countdown #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    burst_countdown_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] index_q;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] saved_len;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count_q <= '0;
            index_q <= '0;
`ifdef AUTO_RELOAD_EN
            saved_len <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
`ifdef AUTO_RELOAD_EN
                        saved_len <= bus.len;
`endif
                        if (bus.len != '0) begin
                            count_q <= bus.len;
                            index_q <= '0;
                            state   <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        count_q <= '0;
                        index_q <= '0;
                    end else if (!bus.hold) begin
                        // Final element keeps its index so it stays visible through DONE.
                        if (count_q > WIDTH'(1)) begin
                            count_q <= count_q - WIDTH'(1);
                            index_q <= index_q + WIDTH'(1);
                        end else begin
                            count_q <= '0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        count_q <= '0;
                        index_q <= '0;
                    end else begin
`ifdef AUTO_RELOAD_EN
                        if (saved_len != '0) begin
                            count_q <= saved_len;
                            index_q <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    count_q <= '0;
                    index_q <= '0;
                end
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    // Abort kills the step in the same cycle it is sampled.
    assign bus.step  = (state == RUN) && !bus.hold && !bus.abort;
    assign bus.index = index_q;
    assign bus.count = count_q;
endmodule
